forth_boot_ctrl: RTL and testbench

Boot/load sequencer for the forth core. Holds the core in reset, receives a program image as a byte stream, and writes 16-bit words into instruction memory through the iaddr-side write port. After validating a checksum it releases the core. A load_req input restarts the whole sequence at any time.

---
 rtl/forth_pkg.sv | 22 ++
 rtl/boot_timeout.sv | 31 +++
 rtl/forth_boot_ctrl.sv | 128 ++++++++++++
 tb/tb_forth_boot_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/forth_pkg.sv
// rtl/forth_pkg.sv - shared types and constants for the forth boot loader
package forth_pkg;

  typedef enum logic [2:0] {
    ST_CNT_LO  = 3'd0,
    ST_CNT_HI  = 3'd1,
    ST_DATA_LO = 3'd2,
    ST_DATA_HI = 3'd3,
    ST_CSUM    = 3'd4,
    ST_RUN     = 3'd5,
    ST_ERR     = 3'd6
  } boot_state_t;

  localparam logic [7:0] BOOT_CSUM_INIT = 8'h00;
  localparam int         IMEM_WORD_W    = 16;

  // States in which the controller is still accepting image bytes.
  function automatic logic rx_open(boot_state_t s);
    return s inside {ST_CNT_LO, ST_CNT_HI, ST_DATA_LO, ST_DATA_HI, ST_CSUM};
  endfunction

endpackage

// File: rtl/boot_timeout.sv
// rtl/boot_timeout.sv - idle-cycle down-counter that flags a stalled load
module boot_timeout #(
  parameter int TIMEOUT = 65535
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int             CW   = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT);

  logic [CW-1:0] remaining;

  // Reload on clear, otherwise count down one per enabled idle cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      remaining <= LOAD;
    end else if (clear) begin
      remaining <= LOAD;
    end else if (en && remaining != '0) begin
      remaining <= remaining - 1'b1;
    end
  end

  // The idle cycle that uses up the last remaining count is the expiring one.
  assign expired = en && (remaining == CW'(1));

endmodule

// File: rtl/forth_boot_ctrl.sv
// rtl/forth_boot_ctrl.sv - byte-stream image loader that gates the forth core reset
module forth_boot_ctrl
  import forth_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int DEPTH   = 1024,
  parameter int TIMEOUT = 65535
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  input  logic                   load_req,
  output logic [ADDR_W-1:0]      imem_waddr,
  output logic [IMEM_WORD_W-1:0] imem_wdata,
  output logic                   imem_we,
  output logic                   cpu_reset,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [ADDR_W:0]        word_count
);

  boot_state_t       state, state_nx;
  logic [7:0]        cnt_lo, data_lo, csum_acc;
  logic [15:0]       n_words, n_req;
  logic [ADDR_W-1:0] idx;
  logic              hs, timed, tmo_expired, n_bad, last_word;

  assign hs        = rx_valid && rx_ready;
  assign n_req     = {rx_data, cnt_lo};
  assign n_bad     = (n_req == 16'd0) || (int'(n_req) > DEPTH);
  assign last_word = (int'(idx) + 1 == int'(n_words));
  // CNT_LO is excluded so waiting for the first byte of a load never times out.
  assign timed     = rx_open(state) && (state != ST_CNT_LO);

  boot_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (load_req || hs || !timed),
    .en      (timed && !hs),
    .expired (tmo_expired)
  );

  // Next-state selection; load_req overrides everything, including a checksum match.
  always_comb begin
    state_nx = state;
    if (load_req) begin
      state_nx = ST_CNT_LO;
    end else if (tmo_expired) begin
      state_nx = ST_ERR;
    end else if (hs) begin
      case (state)
        ST_CNT_LO:  state_nx = ST_CNT_HI;
        ST_CNT_HI:  state_nx = n_bad ? ST_ERR : ST_DATA_LO;
        ST_DATA_LO: state_nx = ST_DATA_HI;
        ST_DATA_HI: state_nx = last_word ? ST_CSUM : ST_DATA_LO;
        ST_CSUM:    state_nx = (rx_data == csum_acc) ? ST_RUN : ST_ERR;
        default:    state_nx = state;
      endcase
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_CNT_LO;
      rx_ready   <= 1'b1;
      cpu_reset  <= 1'b1;
      busy       <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
      word_count <= '0;
      csum_acc   <= BOOT_CSUM_INIT;
      cnt_lo     <= 8'h00;
      data_lo    <= 8'h00;
      n_words    <= 16'h0000;
      idx        <= '0;
    end else begin
      state    <= state_nx;
      rx_ready <= rx_open(state_nx);
      imem_we  <= 1'b0;
      if (load_req) begin
        cpu_reset  <= 1'b1;
        busy       <= 1'b1;
        done       <= 1'b0;
        error      <= 1'b0;
        word_count <= '0;
        csum_acc   <= BOOT_CSUM_INIT;
        idx        <= '0;
      end else begin
        if (state_nx == ST_ERR && state != ST_ERR) begin
          error <= 1'b1;
          busy  <= 1'b0;
        end
        if (state_nx == ST_RUN && state != ST_RUN) begin
          cpu_reset <= 1'b0;
          done      <= 1'b1;
          busy      <= 1'b0;
        end
        if (hs) begin
          if (state != ST_CSUM) csum_acc <= csum_acc ^ rx_data;
          case (state)
            ST_CNT_LO:  cnt_lo <= rx_data;
            ST_CNT_HI: begin
              n_words <= n_req;
              idx     <= '0;
            end
            ST_DATA_LO: data_lo <= rx_data;
            ST_DATA_HI: begin
              imem_we    <= 1'b1;
              imem_waddr <= idx;
              imem_wdata <= {rx_data, data_lo};
              idx        <= idx + 1'b1;
              word_count <= word_count + 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_forth_boot_ctrl.sv
// tb/tb_forth_boot_ctrl.sv - self-checking bench for forth_boot_ctrl
module tb_forth_boot_ctrl;

  localparam int AW    = 10;
  localparam int DEPTH = 1024;
  localparam int TMO   = 40;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          load_req = 1'b0;
  logic          rx_ready, imem_we, cpu_reset, busy, done, error;
  logic [AW-1:0] imem_waddr;
  logic [15:0]   imem_wdata;
  logic [AW:0]   word_count;

  int n_checks = 0;
  int n_fails  = 0;

  logic [7:0]       img_q[$];
  logic [AW+15:0]   exp_q[$];
  logic [AW+15:0]   wr_q[$];

  forth_boot_ctrl #(.ADDR_W(AW), .DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .load_req(load_req), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .imem_we(imem_we),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error), .word_count(word_count)
  );

  always #5 clk = ~clk;

  // Record every write strobe; a strobe held for two cycles shows up as an extra entry.
  always @(negedge clk) if (imem_we === 1'b1) wr_q.push_back({imem_waddr, imem_wdata});

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag, input bit cr, input bit bs, input bit dn,
                              input bit er, input bit rdy);
    check({tag, ".cpu_reset"}, 32'(cpu_reset), 32'(cr));
    check({tag, ".busy"},      32'(busy),      32'(bs));
    check({tag, ".done"},      32'(done),      32'(dn));
    check({tag, ".error"},     32'(error),     32'(er));
    check({tag, ".rx_ready"},  32'(rx_ready),  32'(rdy));
  endtask

  task automatic check_writes(input string tag);
    check({tag, ".nwr"}, 32'(wr_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
      check($sformatf("%s.wr%0d", tag, i), 32'(wr_q[i]), 32'(exp_q[i]));
  endtask

  // Reference image: count, n random words, XOR of every preceding byte (optionally corrupted).
  task automatic build_image(input int n, input bit good);
    logic [7:0]  x;
    logic [15:0] w;
    img_q.delete();
    exp_q.delete();
    img_q.push_back(8'(n));
    img_q.push_back(8'(n >> 8));
    for (int i = 0; i < n; i++) begin
      w = 16'($urandom);
      img_q.push_back(w[7:0]);
      img_q.push_back(w[15:8]);
      exp_q.push_back({AW'(i), w});
    end
    x = 8'h00;
    foreach (img_q[i]) x = x ^ img_q[i];
    img_q.push_back(good ? x : x ^ 8'($urandom_range(1, 255)));
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_image(input int maxgap);
    foreach (img_q[i]) send_byte(img_q[i], $urandom_range(0, maxgap));
  endtask

  task automatic pulse_load_req(input string tag);
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
    wr_q.delete();
    check_status(tag, 1, 1, 0, 0, 1);
    check({tag, ".word_count"}, 32'(word_count), 32'd0);
  endtask

  initial begin
    bit good;
    int n;
    reset = 1'b1;
    #2 reset = 1'b0;
    #2;
    check_status("rst", 1, 1, 0, 0, 1);
    check("rst.imem_we",    32'(imem_we),    32'd0);
    check("rst.imem_waddr", 32'(imem_waddr), 32'd0);
    check("rst.imem_wdata", 32'(imem_wdata), 32'd0);
    check("rst.word_count", 32'(word_count), 32'd0);
    @(posedge clk); #1 reset = 1'b1;

    // Directed two-word image.
    img_q = '{8'h02, 8'h00, 8'h01, 8'h00, 8'h07, 8'he0, 8'he4};
    exp_q = '{{10'd0, 16'h0001}, {10'd1, 16'he007}};
    send_image(0);
    check_status("img2", 0, 0, 1, 0, 0);
    check("img2.word_count", 32'(word_count), 32'd2);
    check_writes("img2");

    // Wrong checksum (correct would be 0x27).
    pulse_load_req("lr0");
    img_q = '{8'h01, 8'h00, 8'h34, 8'h12, 8'h26};
    exp_q = '{{10'd0, 16'h1234}};
    send_image(1);
    check_status("badcs", 1, 0, 0, 1, 0);
    check_writes("badcs");

    // Zero and oversize counts.
    pulse_load_req("lr1");
    exp_q.delete();
    send_byte(8'h00, 0);
    check_status("n0.mid", 1, 1, 0, 0, 1);
    send_byte(8'h00, 0);
    check_status("n0", 1, 0, 0, 1, 0);
    pulse_load_req("lr2");
    send_byte(8'h01, 0);
    send_byte(8'h04, 0);
    check_status("n1025", 1, 0, 0, 1, 0);
    check_writes("nbad");

    // Largest legal image fills every address.
    pulse_load_req("lr3");
    build_image(DEPTH, 1);
    send_image(0);
    check_status("nmax", 0, 0, 1, 0, 0);
    check("nmax.word_count", 32'(word_count), 32'(DEPTH));
    check_writes("nmax");

    // Stall after the first data byte.
    pulse_load_req("lr4");
    build_image(2, 1);
    for (int i = 0; i < 3; i++) send_byte(img_q[i], 0);
    repeat (TMO - 1) @(posedge clk);
    #1 check_status("tmo.before", 1, 1, 0, 0, 1);
    @(posedge clk); #1;
    check_status("tmo", 1, 0, 0, 1, 0);
    send_byte(img_q[3], 0);
    check("tmo.nwr", 32'(wr_q.size()), 32'd0);
    check_status("tmo.after", 1, 0, 0, 1, 0);

    // load_req together with the DATA_HI handshake discards that byte.
    pulse_load_req("lr5");
    build_image(2, 1);
    for (int i = 0; i < 3; i++) send_byte(img_q[i], 0);
    rx_data = img_q[3];
    rx_valid = 1'b1;
    pulse_load_req("lr.datahi");
    rx_valid = 1'b0;
    @(posedge clk); #1;
    check("lr.datahi.nwr", 32'(wr_q.size()), 32'd0);
    build_image(3, 1);
    send_image(2);
    check_status("fresh", 0, 0, 1, 0, 0);
    check_writes("fresh");
    pulse_load_req("lr.run");

    // Random images with random gaps and checksum quality.
    for (int k = 0; k < 6; k++) begin
      n = $urandom_range(1, 12);
      good = 1'($urandom_range(0, 1));
      build_image(n, good);
      send_image(3);
      if (good) check_status($sformatf("rnd%0d", k), 0, 0, 1, 0, 0);
      else      check_status($sformatf("rnd%0d", k), 1, 0, 0, 1, 0);
      check($sformatf("rnd%0d.word_count", k), 32'(word_count), 32'(n));
      check_writes($sformatf("rnd%0d", k));
      pulse_load_req($sformatf("rnd%0d.lr", k));
    end

    // Asynchronous reset in the middle of an image.
    build_image(5, 1);
    for (int i = 0; i < 6; i++) send_byte(img_q[i], 0);
    #2 reset = 1'b0;
    #1;
    check_status("arst", 1, 1, 0, 0, 1);
    check("arst.imem_we",    32'(imem_we),    32'd0);
    check("arst.word_count", 32'(word_count), 32'd0);
    check("arst.imem_waddr", 32'(imem_waddr), 32'd0);
    wr_q.delete();
    @(posedge clk); @(posedge clk); #1;
    check("arst.nwr", 32'(wr_q.size()), 32'd0);
    reset = 1'b1;
    build_image(4, 1);
    send_image(1);
    check_status("arst.load", 0, 0, 1, 0, 0);
    check_writes("arst.load");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
